data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Word-addressed data memory acting as the responder side of the CPU data-memory port.
//  Accepts read/write requests from the datapath initiator (addr = aluout, wdata = writedata).
//  Answers after a programmable wait-state count, so the multicycle CPU can be exercised
//  against realistic memory latency. Sits between the CPU top and the testbench/SoC memory.
// PARAMETERS
//  DEPTH    256  number of 32-bit words; legal word index 0..DEPTH-1
//  LATENCY  2    wait-state cycles between acceptance and response; legal range 0..15
// PORTS
//  clk    in   1   single clock; all logic on the rising edge
//  rst    in   1   reset, synchronous, active-low (0 = reset, sampled on rising clk)
//  req    in   1   request valid; initiator holds it and all inputs stable until ready
//  we     in   1   1 = write, 0 = read
//  be     in   4   byte enables for writes; be[i] enables wdata[8i+7:8i]
//  addr   in   32  byte address; word index = addr[31:2]
//  wdata  in   32  write data
//  rdata  out  32  read data; meaningful only while ready=1
//  ready  out  1   one-cycle response strobe
//  err    out  1   valid with ready: misaligned or out-of-range access
// BEHAVIOUR
//  Reset (rst=0 at an edge): state->IDLE, ready=0, err=0, rdata=0, wait counter=0.
//   Memory array contents are NOT reset.
//  FSM states: IDLE, WAIT, RESP.
//  - IDLE: req=1 -> capture we/be/addr/wdata.
//    Next state is WAIT with cnt=LATENCY-1; if LATENCY==0, next state is RESP directly.
//  - WAIT: cnt decrements each cycle; at cnt==0 the next state is RESP.
//  - Commit: on the edge entering RESP, a write is performed (per-byte be),
//    or a read word is latched into rdata.
//  - RESP: ready=1 for exactly one cycle, then IDLE. req is ignored in RESP.
//    A new request is accepted at the earliest in the following IDLE cycle.
//  - Latency: accept edge -> ready high = LATENCY+1 cycles.
//    Back-to-back throughput is one transaction per LATENCY+2 cycles.
//  - rdata holds its last latched value outside RESP.
//    For writes, rdata holds the previous value (it is not updated).
//  Error rules (checked on captured values):
//   addr[1:0]!=0, or addr[31:2]>=DEPTH -> err=1 with ready, no write, rdata=0.
//  - be==4'b0000 write: legal; ready=1, err=0, memory unchanged.
//  - Reads ignore be and always return the full word.
//  - req and inputs changing in WAIT are a protocol violation.
//    The captured values are used regardless.
//  - Reset during WAIT: transaction aborted, no write occurs, ready stays 0.
//  - Reset coincident with the commit edge: reset wins, no write.
//  - Counter width: 4 bits; no wrap, because it is reloaded only from IDLE.
// STRUCTURE
//  Shared package mem_pkg:
//   - state encodings S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2
//   - WORD_W=32, BE_W=4
//  One sub-module: mem_array (DEPTH x 32).
//   - Synchronous byte-enabled write; synchronous read into the rdata register.
//   - Write-enable and read-enable are driven by the FSM commit pulse.
//  Top holds the FSM, request capture registers, wait counter and error decode.
// TESTING
//  1 Reset: rst=0 for 2 cycles -> ready=0, err=0, rdata=0; FSM in IDLE.
//  2 Write then read, LATENCY=2:
//    - write addr=0x10, wdata=0xDEADBEEF, be=4'hF -> ready exactly 3 cycles after accept.
//    - read addr=0x10 -> rdata=0xDEADBEEF, err=0.
//  3 Byte enables: prior word 0xDEADBEEF.
//    - write be=4'b0101, wdata=0x11223344 -> read returns 0xDE22BE44.
//  4 Errors:
//    - read addr=0x12 -> ready=1, err=1, rdata=0.
//    - write addr=DEPTH*4 -> err=1; word 0 remains unchanged.
//  5 LATENCY=0: read accepted at edge N -> ready=1 in cycle N+1.
//    With req held high, the next accept occurs at edge N+2.
//  6 Reset mid-WAIT: write 0xCAFEF00D to 0x20, pull rst=0 during WAIT.
//    -> ready never pulses; a subsequent read of 0x20 returns its old value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and widths for the data-memory responder.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/mem_array.sv
// Word storage with byte-enabled synchronous write and registered read data.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_d, rdata_q;

  // Byte-lane writes; the array itself is never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read word is latched on a read commit, zeroed on an error commit, else held.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en)       rdata_d = mem[idx];
    else if (rd_clr) rdata_d = '0;
  end

  // Read data register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory port with programmable wait states.
//
// state  | meaning
// S_IDLE | waiting for req; captures request fields when req=1
// S_WAIT | counting down wait states on the captured request
// S_RESP | ready (and err) asserted for one cycle, req ignored
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
  localparam logic [29:0]      IDX_LIMIT = 30'(DEPTH);

  logic [1:0]        state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              we_d, we_q;
  logic [BE_W-1:0]   be_d, be_q;
  logic [WORD_W-1:0] addr_d, addr_q;
  logic [WORD_W-1:0] wdata_d, wdata_q;
  logic              err_d, err_q;

  logic              commit;
  logic              commit_ok;
  logic              bad;
  logic              txn_we;
  logic [BE_W-1:0]   txn_be;
  logic [WORD_W-1:0] txn_addr;
  logic [WORD_W-1:0] txn_wdata;

  // With zero wait states the commit edge is the accept edge, so the live
  // inputs are used there; otherwise the captured copy drives the commit.
  always_comb begin
    if (state_q == S_IDLE) begin
      txn_we    = we;
      txn_be    = be;
      txn_addr  = addr;
      txn_wdata = wdata;
    end else begin
      txn_we    = we_q;
      txn_be    = be_q;
      txn_addr  = addr_q;
      txn_wdata = wdata_q;
    end
    bad = (txn_addr[1:0] != 2'b00) || (txn_addr[31:2] >= IDX_LIMIT);
  end

  // Next-state, countdown and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          be_d    = be;
          addr_d  = addr;
          wdata_d = wdata;
          if (LATENCY == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A commit coinciding with reset must not touch the array.
  assign commit_ok = commit & rst;
  assign err_d     = commit & bad;

  // Control and capture registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (commit_ok & txn_we & ~bad),
    .rd_en  (commit_ok & ~txn_we & ~bad),
    .rd_clr (commit_ok & bad),
    .idx    (txn_addr[IDX_W+1:2]),
    .be     (txn_be),
    .wdata  (txn_wdata),
    .rdata  (rdata)
  );

  assign ready = (state_q == S_RESP);
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with zero wait states.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req2 = 1'b0, we2 = 1'b0;
  logic [3:0]  be2 = 4'h0;
  logic [31:0] addr2 = '0, wdata2 = '0;
  logic [31:0] rdata2;
  logic        ready2, err2;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [3:0]  be0 = 4'h0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [31:0] rdata0;
  logic        ready0, err0;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .be(be2), .addr(addr2),
    .wdata(wdata2), .rdata(rdata2), .ready(ready2), .err(err2)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .be(be0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0)
  );

  // Drives one request on the selected instance (z=1: zero-latency one) and
  // waits for ready. cyc = cycles from accept edge to ready (0 on timeout).
  task automatic txn(input bit z, input bit w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e,
                     output int cyc, output logic rdy_after);
    rd = '0; e = 1'b0; cyc = 0; rdy_after = 1'b0;
    if (z) begin req0 = 1'b1; we0 = w; be0 = b; addr0 = a; wdata0 = d; end
    else   begin req2 = 1'b1; we2 = w; be2 = b; addr2 = a; wdata2 = d; end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (z ? ready0 : ready2) begin
        cyc = k + 1;
        rd  = z ? rdata0 : rdata2;
        e   = z ? err0 : err2;
        break;
      end
    end
    req0 = 1'b0;
    req2 = 1'b0;
    @(posedge clk); #1;
    rdy_after = z ? ready0 : ready2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready2 !== 1'b0) $display("FAIL reset_ready2 got %b want 0", ready2); else pass_cnt++;
    total++; if (err2 !== 1'b0) $display("FAIL reset_err2 got %b want 0", err2); else pass_cnt++;
    total++; if (rdata2 !== 32'h0) $display("FAIL reset_rdata2 got %h want 0", rdata2); else pass_cnt++;
    total++; if (ready0 !== 1'b0) $display("FAIL reset_ready0 got %b want 0", ready0); else pass_cnt++;
    total++; if (err0 !== 1'b0) $display("FAIL reset_err0 got %b want 0", err0); else pass_cnt++;
    total++; if (rdata0 !== 32'h0) $display("FAIL reset_rdata0 got %h want 0", rdata0); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int cyc; logic ra;
    txn(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, e, cyc, ra);
    total++; if (cyc !== 3) $display("FAIL wr_latency got %0d want 3", cyc); else pass_cnt++;
    total++; if (e !== 1'b0) $display("FAIL wr_err got %b want 0", e); else pass_cnt++;
    total++; if (rd !== 32'h0) $display("FAIL wr_rdata_held got %h want 0", rd); else pass_cnt++;
    total++; if (ra !== 1'b0) $display("FAIL wr_ready_one_cycle got %b want 0", ra); else pass_cnt++;
    txn(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, rd, e, cyc, ra);
    total++; if (cyc !== 3) $display("FAIL rd_latency got %0d want 3", cyc); else pass_cnt++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", rd); else pass_cnt++;
    total++; if (e !== 1'b0) $display("FAIL rd_err got %b want 0", e); else pass_cnt++;
    total++; if (ra !== 1'b0) $display("FAIL rd_ready_one_cycle got %b want 0", ra); else pass_cnt++;
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic e; int cyc; logic ra;
    txn(1'b0, 1'b1, 4'b0101, 32'h10, 32'h11223344, rd, e, cyc, ra);
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL be_wr_rdata_held got %h want deadbeef", rd); else pass_cnt++;
    txn(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, rd, e, cyc, ra);
    total++; if (rd !== 32'hDE22BE44) $display("FAIL be_merge got %h want de22be44", rd); else pass_cnt++;
    txn(1'b0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, e, cyc, ra);
    total++; if (e !== 1'b0 || cyc !== 3) $display("FAIL be_zero_resp got err=%b cyc=%0d want err=0 cyc=3", e, cyc); else pass_cnt++;
    txn(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, rd, e, cyc, ra);
    total++; if (rd !== 32'hDE22BE44) $display("FAIL be_zero_nochange got %h want de22be44", rd); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int cyc; logic ra;
    txn(1'b0, 1'b0, 4'hF, 32'h12, 32'h0, rd, e, cyc, ra);
    total++; if (cyc !== 3) $display("FAIL err_misalign_latency got %0d want 3", cyc); else pass_cnt++;
    total++; if (e !== 1'b1) $display("FAIL err_misalign_err got %b want 1", e); else pass_cnt++;
    total++; if (rd !== 32'h0) $display("FAIL err_misalign_rdata got %h want 0", rd); else pass_cnt++;
    txn(1'b0, 1'b1, 4'hF, 32'h0, 32'h01234567, rd, e, cyc, ra);
    txn(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, rd, e, cyc, ra);
    total++; if (rd !== 32'h01234567) $display("FAIL err_word0_seed got %h want 01234567", rd); else pass_cnt++;
    txn(1'b0, 1'b1, 4'hF, 32'd1024, 32'hFFFFFFFF, rd, e, cyc, ra);
    total++; if (e !== 1'b1) $display("FAIL err_range_err got %b want 1", e); else pass_cnt++;
    total++; if (rd !== 32'h0) $display("FAIL err_range_rdata got %h want 0", rd); else pass_cnt++;
    txn(1'b0, 1'b1, 4'hF, 32'h80000010, 32'hFFFFFFFF, rd, e, cyc, ra);
    total++; if (e !== 1'b1) $display("FAIL err_highaddr_err got %b want 1", e); else pass_cnt++;
    txn(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, rd, e, cyc, ra);
    total++; if (rd !== 32'h01234567 || e !== 1'b0) $display("FAIL err_word0_kept got %h err=%b want 01234567 err=0", rd, e); else pass_cnt++;
    txn(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, rd, e, cyc, ra);
    total++; if (rd !== 32'hDE22BE44) $display("FAIL err_word4_kept got %h want de22be44", rd); else pass_cnt++;
  endtask

  task automatic test_latency0();
    logic [31:0] rd; logic e; int cyc; logic ra;
    txn(1'b1, 1'b1, 4'hF, 32'h10, 32'h0BADF00D, rd, e, cyc, ra);
    total++; if (cyc !== 1) $display("FAIL lat0_wr_latency got %0d want 1", cyc); else pass_cnt++;
    total++; if (ra !== 1'b0) $display("FAIL lat0_wr_one_cycle got %b want 0", ra); else pass_cnt++;
    // Hold req: accept at edge N, ready after N, idle after N+1, accept again at N+2.
    req0 = 1'b1; we0 = 1'b0; be0 = 4'h0; addr0 = 32'h10; wdata0 = 32'h0;
    @(posedge clk); #1;
    total++; if (ready0 !== 1'b1 || rdata0 !== 32'h0BADF00D) $display("FAIL lat0_rd_first got ready=%b rdata=%h want 1 0badf00d", ready0, rdata0); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (ready0 !== 1'b0) $display("FAIL lat0_gap got %b want 0", ready0); else pass_cnt++;
    addr0 = 32'h14;
    @(posedge clk); #1;
    total++; if (ready0 !== 1'b1) $display("FAIL lat0_second_accept got %b want 1", ready0); else pass_cnt++;
    req0 = 1'b0;
    @(posedge clk); #1;
    total++; if (ready0 !== 1'b0) $display("FAIL lat0_after got %b want 0", ready0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic e; int cyc; logic ra; int seen;
    txn(1'b0, 1'b1, 4'hF, 32'h20, 32'h55AA55AA, rd, e, cyc, ra);
    // Reset in the first wait cycle.
    req2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 32'h20; wdata2 = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b0; req2 = 1'b0;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (ready2) seen++; end
    rst = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (ready2) seen++; end
    total++; if (seen !== 0) $display("FAIL midwait_no_ready got %0d pulses want 0", seen); else pass_cnt++;
    total++; if (rdata2 !== 32'h0) $display("FAIL midwait_rdata_reset got %h want 0", rdata2); else pass_cnt++;
    txn(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, rd, e, cyc, ra);
    total++; if (rd !== 32'h55AA55AA) $display("FAIL midwait_old_value got %h want 55aa55aa", rd); else pass_cnt++;
    // Reset asserted for the commit edge itself.
    req2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 32'h20; wdata2 = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; req2 = 1'b0;
    @(posedge clk); #1;
    total++; if (ready2 !== 1'b0) $display("FAIL commit_reset_ready got %b want 0", ready2); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, rd, e, cyc, ra);
    total++; if (rd !== 32'h55AA55AA || cyc !== 3) $display("FAIL commit_reset_old_value got %h cyc=%0d want 55aa55aa cyc=3", rd, cyc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_errors();
    test_latency0();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
